// File: rtl/neuron_mac_pkg.sv
// neuron_mac_pkg: Q8.24 fixed-point defaults, constants and FSM state encoding
package neuron_mac_pkg;
    localparam int WIDTH_D = 32;
    localparam int FL_D = 24;
    localparam logic [31:0] Q_ONE = 32'h0100_0000;
    localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
endpackage

// File: rtl/neuron_mac_if.sv
// neuron_mac_if: start/pair handshake and result bus of the neuron MAC
interface neuron_mac_if import neuron_mac_pkg::*; #(parameter int WIDTH = WIDTH_D);
    logic en, start, in_valid, in_ready, busy, out_valid;
    logic [WIDTH-1:0] bias, x, w, sum;
    modport master (output en, start, bias, in_valid, x, w, input in_ready, busy, out_valid, sum);
    modport slave (input en, start, bias, in_valid, x, w, output in_ready, busy, out_valid, sum);
endinterface

// File: rtl/neuron_mac_q_mult.sv
// q_mult: combinational signed fixed-point multiply, product floored to WIDTH bits at FL
module q_mult import neuron_mac_pkg::*; #(
    parameter int WIDTH = WIDTH_D,
    parameter int FL = FL_D
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p
);
    logic signed [2*WIDTH-1:0] prod;
    assign prod = a * b;
    assign p = WIDTH'(prod >>> FL);
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: serial MAC forming bias + sum(x*w) in Q8.24; NEURON_MAC_SAT_EN selects saturating adds
module neuron_mac import neuron_mac_pkg::*; #(
    parameter int WIDTH = WIDTH_D,
    parameter int FL = FL_D,
    parameter int N_IN = 4,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    neuron_mac_if.slave bus
);
    state_t state, state_n;
    logic signed [WIDTH-1:0] acc, acc_n, p;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic hs, last;
    q_mult #(.WIDTH(WIDTH), .FL(FL)) u_mult (.a(bus.x), .b(bus.w), .p(p));
    assign hs = bus.en && bus.in_valid && state == ACC;
    assign last = cnt == CNT_W'(N_IN - 1);
`ifdef NEURON_MAC_SAT_EN
    logic signed [WIDTH:0] s;
    assign s = {acc[WIDTH-1], acc} + {p[WIDTH-1], p};
    // sign bits disagree only on overflow; s[WIDTH] gives the true sign
    assign acc_n = s[WIDTH] == s[WIDTH-1] ? s[WIDTH-1:0]
                 : s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign acc_n = acc + p;
`endif
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (bus.start ? ACC : IDLE)
                : state == ACC ? (bus.in_valid && last ? DONE : ACC)
                : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            acc <= '0;
            cnt <= '0;
            sum_q <= '0;
        end else if (bus.en) begin
            state <= state_n;
            if (state == IDLE && bus.start) begin
                acc <= bus.bias;
                cnt <= '0;
            end else if (hs) begin
                acc <= acc_n;
                cnt <= cnt + 1'b1;
            end
            // result registered with the last pair so it is visible in the DONE cycle
            if (hs && last) sum_q <= acc_n;
        end
    end
    assign bus.in_ready = bus.en && state == ACC;
    assign bus.busy = state != IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.sum = sum_q;
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: table-driven and random checks of neuron_mac against an arithmetic reference model
module tb_neuron_mac;
    import neuron_mac_pkg::*;
    localparam int N = 4;
    typedef logic [N-1:0][31:0] arr_t;
    typedef struct {
        logic [31:0] bias;
        arr_t x;
        arr_t w;
        logic [31:0] exp;
        bit gaps;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int n_chk = 0;
    int n_fail = 0;
    vec_t vecs[13];

    neuron_mac_if #(.WIDTH(32)) bus ();
    neuron_mac #(.WIDTH(32), .FL(24), .N_IN(N), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] b, input arr_t xv, input arr_t wv);
        longint acc;
        acc = longint'($signed(b));
        for (int i = 0; i < N; i++) begin
            longint prod;
            int p;
            prod = longint'($signed(xv[i])) * longint'($signed(wv[i]));
            p = int'(prod >>> 24);
            acc = acc + longint'(p);
`ifdef NEURON_MAC_SAT_EN
            if (acc > 64'sd2147483647) acc = 64'sd2147483647;
            else if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`else
            acc = longint'(int'(acc));
`endif
        end
        return acc[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one neuron starting in the current IDLE cycle; leaves the bench in the next IDLE cycle.
    task automatic neuron(input logic [31:0] b, input arr_t xv, input arr_t wv, input bit gaps,
                          input logic [31:0] exp, input string nm);
        int i = 0;
        int cyc = 0;
        bit early = 0;
        bus.start = 1'b1;
        bus.bias = b;
        bus.in_valid = 1'b1;
        bus.x = 32'h7F00_0000;
        bus.w = 32'h7F00_0000;
        step();
        bus.start = 1'b0;
        while (i < N && cyc < 100) begin
            bus.x = xv[i];
            bus.w = wv[i];
            bus.in_valid = gaps ? 1'($urandom_range(1)) : 1'b1;
            bus.start = gaps ? 1'($urandom_range(1)) : 1'b0;
            @(negedge clk);
            if (cyc == 0) check({nm, " in_ready after start"}, 32'(bus.in_ready), 32'd1);
            if (bus.out_valid) early = 1'b1;
            if (bus.in_valid && bus.in_ready) i++;
            cyc++;
            step();
        end
        check({nm, " pairs accepted"}, 32'(i), 32'(N));
        check({nm, " early out_valid"}, 32'(early), 32'd0);
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check({nm, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({nm, " sum"}, bus.sum, exp);
        check({nm, " in_ready in done"}, 32'(bus.in_ready), 32'd0);
        step();
        @(negedge clk);
        check({nm, " out_valid pulse end"}, 32'(bus.out_valid), 32'd0);
        check({nm, " busy in idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        bus.en = 1'b1;
        bus.start = 1'b0;
        bus.bias = '0;
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.w = '0;
        @(negedge clk);
        check("reset sum", bus.sum, 32'h0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd0);
        step();
        rst = 1'b1;
        step();

        vecs[0] = '{32'h0080_0000, {N{Q_ONE}}, {N{32'h0040_0000}}, 32'h0180_0000, 1'b0};
        vecs[1] = '{32'h0, {N{32'hFF00_0000}}, {N{32'h0080_0000}}, 32'hFE00_0000, 1'b0};
`ifdef NEURON_MAC_SAT_EN
        vecs[2] = '{32'h0, {N{32'h6400_0000}}, {N{Q_ONE}}, Q_MAX, 1'b0};
        vecs[3] = '{32'h0, {N{32'h9C00_0000}}, {N{Q_ONE}}, Q_MIN, 1'b1};
`else
        vecs[2] = '{32'h0, {N{32'h6400_0000}}, {N{Q_ONE}}, 32'h9000_0000, 1'b0};
        vecs[3] = '{32'h0, {N{32'h9C00_0000}}, {N{Q_ONE}}, 32'h7000_0000, 1'b1};
`endif
        vecs[4] = '{32'h0, {N{32'hFFFF_FFFF}}, {N{32'h0080_0000}}, 32'hFFFF_FFFC, 1'b0};
        for (int k = 5; k < 13; k++) begin
            vecs[k].bias = $urandom();
            for (int j = 0; j < N; j++) begin
                vecs[k].x[j] = (k < 9) ? 32'($signed(32'($urandom_range(32'h0400_0000))) - 32'sh0200_0000)
                                       : $urandom();
                vecs[k].w[j] = $urandom();
            end
            vecs[k].exp = model(vecs[k].bias, vecs[k].x, vecs[k].w);
            vecs[k].gaps = k[0];
        end
        for (int k = 0; k < 13; k++)
            neuron(vecs[k].bias, vecs[k].x, vecs[k].w, vecs[k].gaps, vecs[k].exp, $sformatf("vec%0d", k));

        // in_valid in IDLE is ignored and sum holds between results
        bus.in_valid = 1'b1;
        bus.x = Q_ONE;
        bus.w = Q_ONE;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle in_ready", 32'(bus.in_ready), 32'd0);
            check("idle sum hold", bus.sum, vecs[12].exp);
            step();
        end
        bus.in_valid = 1'b0;

        // in_valid gaps and en low for 3 cycles in ACC, then en low during DONE
        bus.start = 1'b1;
        bus.bias = 32'h0080_0000;
        bus.x = Q_ONE;
        bus.w = 32'h0040_0000;
        step();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        bus.in_valid = 1'b1;
        bus.en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall en0 in_ready", 32'(bus.in_ready), 32'd0);
            check("stall en0 busy", 32'(bus.busy), 32'd1);
            step();
        end
        bus.en = 1'b1;
        step();
        step();
        @(negedge clk);
        check("stall no early out_valid", 32'(bus.out_valid), 32'd0);
        step();
        bus.en = 1'b0;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall done out_valid held", 32'(bus.out_valid), 32'd1);
            check("stall sum", bus.sum, 32'h0180_0000);
            step();
        end
        bus.en = 1'b1;
        step();
        @(negedge clk);
        check("stall out_valid not duplicated", 32'(bus.out_valid), 32'd0);

        // async reset mid-accumulation discards the partial sum
        step();
        bus.start = 1'b1;
        bus.bias = 32'h0080_0000;
        step();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        check("midrst sum", bus.sum, 32'h0);
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        neuron(32'h0, {N{32'h0080_0000}}, {N{32'h0080_0000}}, 1'b0, Q_ONE, "after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
